memoria_dp_init: RTL and testbench

Parametrised true dual-port synchronous memory: the next generation of the project's 2-port memory block. It generalises address/data width and adds:
- a post-reset clear sweep;
- registered read outputs with valid strobes;
- deterministic same-address collision handling with a selectable read-during-write mode.

It sits between the two channel controllers that share the buffer storage.

---
 rtl/memoria_dp_init.sv | 88 ++++++++
 tb/tb_memoria_dp_init.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/memoria_dp_init.sv
// memoria_dp_init: true dual-port RAM with post-reset clear sweep, registered reads and collision handling
// Ports: clk; reset (async, active-high); per port enX/rwX/AddrX/DataInX in, DataOutX/validX out;
//        busy while the clear sweep runs; collision pulses after a same-address access involving a write.
module memoria_dp_init #(
  parameter int AW      = 3,
  parameter int DW      = 4,
  parameter bit RDW_NEW = 1'b0,
  parameter bit PRIO_B  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enA,
  input  logic          rwA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] DataInA,
  output logic [DW-1:0] DataOutA,
  output logic          validA,
  input  logic          enB,
  input  logic          rwB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataInB,
  output logic [DW-1:0] DataOutB,
  output logic          validB,
  output logic          busy,
  output logic          collision
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic valid_a_q, valid_a_d, valid_b_q, valid_b_d, coll_q, coll_d;
  logic [DW-1:0] mem [2**AW];
  logic ready, same, rd_a, wr_a, rd_b, wr_b, we_a, we_b;

  always_comb begin
    ready     = state_q == READY;
    same      = AddrA == AddrB;
    rd_a      = ready & enA & rwA;
    wr_a      = ready & enA & ~rwA;
    rd_b      = ready & enB & rwB;
    wr_b      = ready & enB & ~rwB;
    // on a write-write clash only the priority port reaches the array
    we_a      = wr_a & ~(PRIO_B & wr_b & same);
    we_b      = wr_b & ~(!PRIO_B & wr_a & same);
    state_d   = (!ready && cnt_q == '1) ? READY : state_q;
    cnt_d     = ready ? cnt_q : cnt_q + AW'(1);
    // the array still holds the old word this edge, so forwarding gives new-data behaviour
    dout_a_d  = rd_a ? ((RDW_NEW && wr_b && same) ? DataInB : mem[AddrA]) : dout_a_q;
    dout_b_d  = rd_b ? ((RDW_NEW && wr_a && same) ? DataInA : mem[AddrB]) : dout_b_q;
    valid_a_d = rd_a;
    valid_b_d = rd_b;
    coll_d    = ready & enA & enB & same & ~(rwA & rwB);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      dout_a_q  <= '0;
      dout_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_a_q  <= dout_a_d;
      dout_b_q  <= dout_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      coll_q    <= coll_d;
    end

  // storage is deliberately not reset; the sweep zeroes it one word per edge
  always_ff @(posedge clk)
    if (!ready) mem[cnt_q] <= '0;
    else begin
      if (we_a) mem[AddrA] <= DataInA;
      if (we_b) mem[AddrB] <= DataInB;
    end

  assign DataOutA  = dout_a_q;
  assign DataOutB  = dout_b_q;
  assign validA    = valid_a_q;
  assign validB    = valid_b_q;
  assign collision = coll_q;
  assign busy      = state_q == CLEAR;
endmodule

// File: tb/tb_memoria_dp_init.sv
// tb_memoria_dp_init: scoreboard bench for a default instance and an AW=5/DW=8 new-data, port-B-priority instance
module tb_memoria_dp_init;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic enA, rwA, enB, rwB, validA, validB, busy, collision;
  logic [2:0] AddrA, AddrB;
  logic [3:0] DataInA, DataInB, DataOutA, DataOutB;
  logic en2A, rw2A, en2B, rw2B, valid2A, valid2B, busy2, collision2;
  logic [4:0] addr2A, addr2B;
  logic [7:0] din2A, din2B, dout2A, dout2B;
  int errors = 0, checks = 0;
  logic [3:0] m1 [8];
  logic [7:0] m2 [32];
  logic [3:0] qa1 [$], qb1 [$];
  logic [7:0] qa2 [$], qb2 [$];
  logic [3:0] e1;
  logic [7:0] e2;

  memoria_dp_init dut (
    .clk(clk), .reset(reset),
    .enA(enA), .rwA(rwA), .AddrA(AddrA), .DataInA(DataInA), .DataOutA(DataOutA), .validA(validA),
    .enB(enB), .rwB(rwB), .AddrB(AddrB), .DataInB(DataInB), .DataOutB(DataOutB), .validB(validB),
    .busy(busy), .collision(collision)
  );

  memoria_dp_init #(.AW(5), .DW(8), .RDW_NEW(1'b1), .PRIO_B(1'b1)) dut2 (
    .clk(clk), .reset(reset),
    .enA(en2A), .rwA(rw2A), .AddrA(addr2A), .DataInA(din2A), .DataOutA(dout2A), .validA(valid2A),
    .enB(en2B), .rwB(rw2B), .AddrB(addr2B), .DataInB(din2B), .DataOutB(dout2B), .validB(valid2B),
    .busy(busy2), .collision(collision2)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task idle;
    enA = 0; enB = 0; en2A = 0; en2B = 0;
  endtask

  task test_reset;
    enA = 0; rwA = 0; AddrA = 0; DataInA = 0; enB = 0; rwB = 0; AddrB = 0; DataInB = 0;
    en2A = 0; rw2A = 0; addr2A = 0; din2A = 0; en2B = 0; rw2B = 0; addr2B = 0; din2B = 0;
    reset = 1; step; step;
    checks++; if ({busy, DataOutA, DataOutB, validA, validB, collision} !== 12'h800) begin errors++; $display("FAIL reset1 got %h exp 800", {busy, DataOutA, DataOutB, validA, validB, collision}); end
    checks++; if ({busy2, dout2A, dout2B, valid2A, valid2B, collision2} !== 20'h80000) begin errors++; $display("FAIL reset2 got %h exp 80000", {busy2, dout2A, dout2B, valid2A, valid2B, collision2}); end
    enA = 1; rwA = 0; AddrA = 0; DataInA = 4'hF; enB = 1; rwB = 1; AddrB = 0;
    en2A = 1; rw2A = 1; addr2A = 1; en2B = 1; rw2B = 0; addr2B = 1; din2B = 8'hFF;
    reset = 0;
    for (int i = 1; i <= 4; i++) begin
      step;
      checks++; if ({busy, validA, validB, collision} !== 4'b1000) begin errors++; $display("FAIL sweep_req edge %0d got %b exp 1000", i, {busy, validA, validB, collision}); end
    end
    reset = 1; #1;
    checks++; if ({busy, DataOutA, DataOutB, validA, validB, collision} !== 12'h800) begin errors++; $display("FAIL sweep_reset got %h exp 800", {busy, DataOutA, DataOutB, validA, validB, collision}); end
    step; reset = 0;
    for (int i = 1; i <= 32; i++) begin
      step;
      if (i <= 8) begin
        checks++; if ({busy, validA, validB, collision} !== {(i < 8), 3'b000}) begin errors++; $display("FAIL sweep1 edge %0d got %b exp %b", i, {busy, validA, validB, collision}, {(i < 8), 3'b000}); end
      end
      checks++; if ({busy2, valid2A, valid2B, collision2} !== {(i < 32), 3'b000}) begin errors++; $display("FAIL sweep2 edge %0d got %b exp %b", i, {busy2, valid2A, valid2B, collision2}, {(i < 32), 3'b000}); end
      if (i == 8) begin enA = 0; enB = 0; end
    end
    idle;
    foreach (m1[i]) m1[i] = 4'h0;
    foreach (m2[i]) m2[i] = 8'h00;
  endtask

  task test_read_zero;
    for (int i = 0; i < 8; i++) begin
      enA = 1; rwA = 1; AddrA = 3'(i); enB = 1; rwB = 1; AddrB = 3'(7 - i);
      qa1.push_back(m1[AddrA]); qb1.push_back(m1[AddrB]);
      step;
      checks++; if ({validA, validB, collision} !== 3'b110) begin errors++; $display("FAIL rdzero flags addr %0d got %b exp 110", i, {validA, validB, collision}); end
      if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL rdzero A addr %0d got %h exp %h", i, DataOutA, e1); end end
      if (validB) begin e1 = qb1.pop_front(); checks++; if (DataOutB !== e1) begin errors++; $display("FAIL rdzero B addr %0d got %h exp %h", 7 - i, DataOutB, e1); end end
    end
    idle; step;
    checks++; if ({validA, validB} !== 2'b00) begin errors++; $display("FAIL rdzero valid_drop got %b exp 00", {validA, validB}); end
  endtask

  task test_write_read;
    enA = 1; rwA = 0; AddrA = 3'b010; DataInA = 4'b1001; m1[2] = 4'b1001;
    step;
    checks++; if ({validA, validB, collision} !== 3'b000) begin errors++; $display("FAIL wr flags got %b exp 000", {validA, validB, collision}); end
    enA = 0; enB = 1; rwB = 1; AddrB = 3'b010; qb1.push_back(m1[2]);
    step;
    checks++; if (validB !== 1'b1) begin errors++; $display("FAIL wr_rd validB got %b exp 1", validB); end
    if (validB) begin e1 = qb1.pop_front(); checks++; if (DataOutB !== e1) begin errors++; $display("FAIL wr_rd data got %h exp %h", DataOutB, e1); end end
    idle; step;
    checks++; if ({validB, DataOutB} !== 5'b01001) begin errors++; $display("FAIL hold got %b exp 01001", {validB, DataOutB}); end
  endtask

  task test_ww_collision;
    enA = 1; rwA = 0; AddrA = 2; DataInA = 4'b1001; enB = 1; rwB = 0; AddrB = 2; DataInB = 4'b1010;
    en2A = 1; rw2A = 0; addr2A = 2; din2A = 8'h09; en2B = 1; rw2B = 0; addr2B = 2; din2B = 8'h0A;
    m1[2] = 4'b1001; m2[2] = 8'h0A;
    step;
    checks++; if ({collision, validA, validB} !== 3'b100) begin errors++; $display("FAIL ww coll1 got %b exp 100", {collision, validA, validB}); end
    checks++; if ({collision2, valid2A, valid2B} !== 3'b100) begin errors++; $display("FAIL ww coll2 got %b exp 100", {collision2, valid2A, valid2B}); end
    rwA = 1; rwB = 1; rw2A = 1; rw2B = 1;
    qa1.push_back(m1[2]); qb1.push_back(m1[2]); qa2.push_back(m2[2]); qb2.push_back(m2[2]);
    step;
    checks++; if ({validA, validB, collision, valid2A, valid2B, collision2} !== 6'b110110) begin errors++; $display("FAIL rr flags got %b exp 110110", {validA, validB, collision, valid2A, valid2B, collision2}); end
    if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL ww win1 A got %h exp %h", DataOutA, e1); end end
    if (validB) begin e1 = qb1.pop_front(); checks++; if (DataOutB !== e1) begin errors++; $display("FAIL ww win1 B got %h exp %h", DataOutB, e1); end end
    if (valid2A) begin e2 = qa2.pop_front(); checks++; if (dout2A !== e2) begin errors++; $display("FAIL ww win2 A got %h exp %h", dout2A, e2); end end
    if (valid2B) begin e2 = qb2.pop_front(); checks++; if (dout2B !== e2) begin errors++; $display("FAIL ww win2 B got %h exp %h", dout2B, e2); end end
    idle;
  endtask

  task test_rdw;
    enA = 1; rwA = 0; AddrA = 2; DataInA = 4'b0110; enB = 1; rwB = 1; AddrB = 2;
    en2A = 1; rw2A = 0; addr2A = 2; din2A = 8'h66; en2B = 1; rw2B = 1; addr2B = 2;
    qb1.push_back(m1[2]); m1[2] = 4'b0110;
    qb2.push_back(8'h66); m2[2] = 8'h66;
    step;
    checks++; if ({collision, validA, validB, collision2, valid2A, valid2B} !== 6'b101101) begin errors++; $display("FAIL rdw flags got %b exp 101101", {collision, validA, validB, collision2, valid2A, valid2B}); end
    if (validB) begin e1 = qb1.pop_front(); checks++; if (DataOutB !== e1) begin errors++; $display("FAIL rdw old got %h exp %h", DataOutB, e1); end end
    if (valid2B) begin e2 = qb2.pop_front(); checks++; if (dout2B !== e2) begin errors++; $display("FAIL rdw new got %h exp %h", dout2B, e2); end end
    rwA = 1; rwB = 0; DataInB = 4'b0011; rw2A = 1; rw2B = 0; din2B = 8'h33;
    qa1.push_back(m1[2]); m1[2] = 4'b0011;
    qa2.push_back(8'h33); m2[2] = 8'h33;
    step;
    checks++; if ({collision, validA, validB, collision2, valid2A, valid2B} !== 6'b110110) begin errors++; $display("FAIL b2b flags got %b exp 110110", {collision, validA, validB, collision2, valid2A, valid2B}); end
    if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL b2b old got %h exp %h", DataOutA, e1); end end
    if (valid2A) begin e2 = qa2.pop_front(); checks++; if (dout2A !== e2) begin errors++; $display("FAIL b2b new got %h exp %h", dout2A, e2); end end
    idle; step;
    checks++; if ({collision, collision2} !== 2'b00) begin errors++; $display("FAIL coll_drop got %b exp 00", {collision, collision2}); end
    enA = 1; rwA = 1; AddrA = 2; en2A = 1; rw2A = 1; addr2A = 2;
    qa1.push_back(m1[2]); qa2.push_back(m2[2]);
    step;
    if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL rdw stored1 got %h exp %h", DataOutA, e1); end end
    if (valid2A) begin e2 = qa2.pop_front(); checks++; if (dout2A !== e2) begin errors++; $display("FAIL rdw stored2 got %h exp %h", dout2A, e2); end end
    idle;
  endtask

  task test_same_port;
    enA = 1; rwA = 1; AddrA = 5; qa1.push_back(m1[5]);
    step;
    rwA = 0; DataInA = 4'hC; m1[5] = 4'hC;
    if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL rtw pre got %h exp %h", DataOutA, e1); end end
    step;
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL rtw wr_valid got %b exp 0", validA); end
    rwA = 1; qa1.push_back(m1[5]);
    step;
    if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL rtw post got %h exp %h", DataOutA, e1); end end
    idle;
  endtask

  task test_independent;
    for (int k = 0; k < 16; k++) begin
      en2A = 1; rw2A = 0; addr2A = 5'(2 * k); din2A = 8'($urandom);
      en2B = 1; rw2B = 0; addr2B = 5'(2 * k + 1); din2B = 8'($urandom);
      m2[addr2A] = din2A; m2[addr2B] = din2B;
      step;
      checks++; if ({valid2A, valid2B, collision2} !== 3'b000) begin errors++; $display("FAIL ind_wr flags k %0d got %b exp 000", k, {valid2A, valid2B, collision2}); end
    end
    for (int i = 0; i < 32; i++) begin
      en2A = 1; rw2A = 1; addr2A = 5'(i); en2B = 1; rw2B = 1; addr2B = 5'(i + 16);
      qa2.push_back(m2[addr2A]); qb2.push_back(m2[addr2B]);
      step;
      checks++; if ({valid2A, valid2B, collision2} !== 3'b110) begin errors++; $display("FAIL ind_rd flags i %0d got %b exp 110", i, {valid2A, valid2B, collision2}); end
      if (valid2A) begin e2 = qa2.pop_front(); checks++; if (dout2A !== e2) begin errors++; $display("FAIL ind_rd A i %0d got %h exp %h", i, dout2A, e2); end end
      if (valid2B) begin e2 = qb2.pop_front(); checks++; if (dout2B !== e2) begin errors++; $display("FAIL ind_rd B i %0d got %h exp %h", i, dout2B, e2); end end
    end
    idle; step;
    checks++; if ({valid2A, valid2B} !== 2'b00) begin errors++; $display("FAIL ind valid_drop got %b exp 00", {valid2A, valid2B}); end
  endtask

  task test_async_reset;
    enA = 1; rwA = 1; AddrA = 5; qa1.push_back(m1[5]);
    step;
    if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL pre_reset got %h exp %h", DataOutA, e1); end end
    idle; #2;
    reset = 1; #1;
    checks++; if ({busy, DataOutA, DataOutB, validA, validB, collision} !== 12'h800) begin errors++; $display("FAIL async1 got %h exp 800", {busy, DataOutA, DataOutB, validA, validB, collision}); end
    checks++; if ({busy2, dout2A, dout2B} !== 17'h10000) begin errors++; $display("FAIL async2 got %h exp 10000", {busy2, dout2A, dout2B}); end
    step; reset = 0;
    for (int i = 1; i <= 8; i++) begin
      step;
      checks++; if (busy !== (i < 8)) begin errors++; $display("FAIL resweep edge %0d got %b exp %b", i, busy, (i < 8)); end
    end
    enA = 1; rwA = 1; AddrA = 5; qa1.push_back(4'h0);
    step;
    if (validA) begin e1 = qa1.pop_front(); checks++; if (DataOutA !== e1) begin errors++; $display("FAIL resweep clear got %h exp %h", DataOutA, e1); end end
    idle;
  endtask

  initial begin
    test_reset;
    test_read_zero;
    test_write_read;
    test_ww_collision;
    test_rdw;
    test_same_port;
    test_independent;
    test_async_reset;
    step;
    checks++; if (qa1.size() + qb1.size() + qa2.size() + qb2.size() != 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", qa1.size() + qb1.size() + qa2.size() + qb2.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
